// File: rtl/e1_buf_arb_if.sv
// ---------------------------------------------------------------------------
// e1_buf_arb_if
//
// Port bundle for the shared 8-bit synchronous buffer RAM used by the E1
// framers. The arbiter drives the address/strobe side; the RAM (or a model
// of it) returns read data one cycle after mem_re.
//
// Signals:
//   mem_addr  [AW-1:0]  RAM address {unit, mf LSBs, frame, ts}
//   mem_wdata [7:0]     RAM write data
//   mem_we              RAM write enable
//   mem_re              RAM read enable
//   mem_rdata [7:0]     RAM read data, valid the cycle after mem_re
//
// Modports:
//   master  - arbiter side (drives addr/wdata/we/re, samples rdata)
//   slave   - RAM side     (samples addr/wdata/we/re, drives rdata)
// ---------------------------------------------------------------------------
interface e1_buf_arb_if #(
  parameter int AW = 12
);

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/e1_buf_arb.sv
// ---------------------------------------------------------------------------
// e1_buf_arb
//
// Shared-buffer arbiter for the E1 core. N framer units each own an RX
// byte-write strobe and a TX byte-read strobe. Every strobe is parked in a
// one-entry holding slot, pending slots are served round-robin at one RAM
// access per cycle, and TX read data comes back into a per-unit register.
// This lets all framers share a single SPRAM.
//
// Requester index k = 2*u + d  (d = 0 RX write, d = 1 TX read).
//
// Parameters:
//   N    number of E1 units (requesters = 2*N)
//   MFW  width of the multiframe index on the requester ports
//   MFB  multiframe LSBs used for addressing (1..MFW)
//   UB   unit-index bits in the address (derived)
//   AW   RAM address width UB+MFB+9 (derived)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data  [8N]       RX byte per unit
//   rx_ts    [5N]       RX timeslot per unit
//   rx_frame [4N]       RX frame per unit
//   rx_mf    [MFW*N]    RX multiframe per unit
//   rx_we    [N]        1-cycle RX write strobe per unit
//   tx_ts/tx_frame/tx_mf  TX coordinates per unit
//   tx_re    [N]        1-cycle TX read strobe per unit
//   tx_data  [8N]       last TX byte fetched per unit
//   tx_busy  [N]        TX read pending or in flight per unit
//   mem                 shared RAM port (e1_buf_arb_if.master)
//   drop_cnt [16N]      per-requester 8-bit saturating drop counters,
//                       {tx,rx} per unit
//
// Build option:
//   E1_BUF_ARB_STATS_EN  when defined, drop_cnt counters are implemented;
//                        otherwise drop_cnt is tied to zero.
// ---------------------------------------------------------------------------
module e1_buf_arb #(
  parameter  int N   = 2,
  parameter  int MFW = 7,
  parameter  int MFB = 2,
  localparam int UB  = (N > 1) ? $clog2(N) : 1,
  localparam int AW  = UB + MFB + 9
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [8*N-1:0]    rx_data,
  input  logic [5*N-1:0]    rx_ts,
  input  logic [4*N-1:0]    rx_frame,
  input  logic [MFW*N-1:0]  rx_mf,
  input  logic [N-1:0]      rx_we,

  input  logic [5*N-1:0]    tx_ts,
  input  logic [4*N-1:0]    tx_frame,
  input  logic [MFW*N-1:0]  tx_mf,
  input  logic [N-1:0]      tx_re,
  output logic [8*N-1:0]    tx_data,
  output logic [N-1:0]      tx_busy,

  e1_buf_arb_if.master      mem,

  output logic [16*N-1:0]   drop_cnt
);

  localparam int R  = 2 * N;
  localparam int PW = $clog2(R);

  // Holding slots: one per requester. Only RX slots carry write data, so
  // the data array is indexed by unit rather than by requester.
  logic [R-1:0]   pend;
  logic [4:0]     slot_ts    [R];
  logic [3:0]     slot_frame [R];
  logic [MFB-1:0] slot_mf    [R];
  logic [7:0]     slot_wdata [N];

  logic [R-1:0]   strobe;
  logic [R-1:0]   accept;
  logic [R-1:0]   gnt;
  logic           gnt_valid;
  logic [PW-1:0]  gnt_idx;
  logic [UB-1:0]  gnt_unit;
  logic [PW-1:0]  next_ptr;
  logic [AW-1:0]  issue_addr;
  logic [PW-1:0]  ptr;

  // Read tag: stage 1 travels alongside mem_re, stage 2 lines up with the
  // cycle in which mem_rdata is valid and tells us which unit to load.
  logic           rd_v1;
  logic [UB-1:0]  rd_u1;
  logic           rd_v2;
  logic [UB-1:0]  rd_u2;

  // Multiframe bits above MFB never reach the address.
  logic           unused_mf;
  assign unused_mf = ^{rx_mf, tx_mf};

  // Flatten the per-unit RX/TX strobes into the requester vector so the
  // arbiter and slot logic can work on k = 2*u + d directly.
  always_comb begin
    strobe = '0;
    for (int u = 0; u < N; u++) begin
      strobe[2*u]   = rx_we[u];
      strobe[2*u+1] = tx_re[u];
    end
  end

  // Round-robin search: walk the pending vector starting at ptr and take
  // the first hit. Only one grant can come out, so mem_we and mem_re can
  // never be raised together.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt       = '0;
    for (int i = 0; i < R; i++) begin
      cand = (int'(ptr) + i) % R;
      if (!gnt_valid && pend[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // A strobe is taken if its slot is free or is being emptied by this
  // cycle's grant; that second case is what lets back-to-back strobes on a
  // granted slot go through without a drop.
  assign accept   = strobe & (~pend | gnt);
  assign gnt_unit = UB'(gnt_idx >> 1);
  assign next_ptr = (gnt_idx == PW'(R - 1)) ? '0 : gnt_idx + 1'b1;

  assign issue_addr = {gnt_unit, slot_mf[gnt_idx], slot_frame[gnt_idx],
                       slot_ts[gnt_idx]};

  // Slot bookkeeping. pend rises on an accepted strobe and falls on grant;
  // an accepted strobe wins over the grant so a coincident re-strobe keeps
  // the slot pending with its new contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      for (int k = 0; k < R; k++) begin
        slot_ts[k]    <= '0;
        slot_frame[k] <= '0;
        slot_mf[k]    <= '0;
      end
      for (int u = 0; u < N; u++) begin
        slot_wdata[u] <= '0;
      end
    end else begin
      pend <= accept | (pend & ~gnt);
      for (int u = 0; u < N; u++) begin
        if (accept[2*u]) begin
          slot_ts[2*u]    <= rx_ts[5*u +: 5];
          slot_frame[2*u] <= rx_frame[4*u +: 4];
          slot_mf[2*u]    <= rx_mf[MFW*u +: MFB];
          slot_wdata[u]   <= rx_data[8*u +: 8];
        end
        if (accept[2*u+1]) begin
          slot_ts[2*u+1]    <= tx_ts[5*u +: 5];
          slot_frame[2*u+1] <= tx_frame[4*u +: 4];
          slot_mf[2*u+1]    <= tx_mf[MFW*u +: MFB];
        end
      end
    end
  end

  // Grant issue and read return. The RAM strobes are registered from the
  // grant, so a strobe at cycle t shows on the RAM port at t+2. Address and
  // write data hold their last value when idle to avoid needless toggling.
  // Reset clears the read tag so a read in flight never lands in tx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_re    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      rd_v1         <= 1'b0;
      rd_u1         <= '0;
      rd_v2         <= 1'b0;
      rd_u2         <= '0;
      tx_data       <= '0;
    end else begin
      mem.mem_we <= gnt_valid & ~gnt_idx[0];
      mem.mem_re <= gnt_valid &  gnt_idx[0];
      if (gnt_valid) begin
        ptr          <= next_ptr;
        mem.mem_addr <= issue_addr;
        if (!gnt_idx[0]) begin
          mem.mem_wdata <= slot_wdata[gnt_unit];
        end
      end
      rd_v1 <= gnt_valid & gnt_idx[0];
      rd_u1 <= gnt_unit;
      rd_v2 <= rd_v1;
      rd_u2 <= rd_u1;
      for (int u = 0; u < N; u++) begin
        if (rd_v2 && (rd_u2 == UB'(u))) begin
          tx_data[8*u +: 8] <= mem.mem_rdata;
        end
      end
    end
  end

  // A unit is busy from the moment its TX slot is pending until its read
  // data has been written into tx_data.
  always_comb begin
    tx_busy = '0;
    for (int u = 0; u < N; u++) begin
      tx_busy[u] = pend[2*u+1]
                 | (rd_v1 && (rd_u1 == UB'(u)))
                 | (rd_v2 && (rd_u2 == UB'(u)));
    end
  end

`ifdef E1_BUF_ARB_STATS_EN
  logic [R-1:0] drop;
  logic [7:0]   drop_q [R];

  assign drop = strobe & pend & ~gnt;

  // Drop counters stick at 0xFF so a long overload stays visible instead
  // of wrapping back to a small number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < R; k++) begin
        drop_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < R; k++) begin
        if (drop[k] && (drop_q[k] != 8'hFF)) begin
          drop_q[k] <= drop_q[k] + 8'd1;
        end
      end
    end
  end

  // Requester order k = 2*u + d packs naturally as {tx,rx} per unit.
  always_comb begin
    drop_cnt = '0;
    for (int k = 0; k < R; k++) begin
      drop_cnt[8*k +: 8] = drop_q[k];
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_e1_buf_arb.sv
// ---------------------------------------------------------------------------
// tb_e1_buf_arb
//
// Self-checking bench for e1_buf_arb with N=2, MFW=7, MFB=2. Expected RAM
// accesses and TX returns are queued when a strobe is driven; a negedge
// monitor pops and compares them as the DUT produces them. A small RAM
// model serves reads from a table preloaded by the stimulus.
// ---------------------------------------------------------------------------
module tb_e1_buf_arb;

  localparam int N   = 2;
  localparam int MFW = 7;
  localparam int MFB = 2;
  localparam int AW  = 12;

`ifdef E1_BUF_ARB_STATS_EN
  localparam logic [31:0] DROP_ONE = 32'h0001_0000;
  localparam logic [31:0] DROP_SAT = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] DROP_ONE = 32'h0000_0000;
  localparam logic [31:0] DROP_SAT = 32'h0000_0000;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    int            cyc;
  } mem_exp_t;

  typedef struct {
    int         unit;
    logic [7:0] data;
    int         cyc;
  } tx_exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [8*N-1:0]    rx_data = '0;
  logic [5*N-1:0]    rx_ts = '0;
  logic [4*N-1:0]    rx_frame = '0;
  logic [MFW*N-1:0]  rx_mf = '0;
  logic [N-1:0]      rx_we = '0;
  logic [5*N-1:0]    tx_ts = '0;
  logic [4*N-1:0]    tx_frame = '0;
  logic [MFW*N-1:0]  tx_mf = '0;
  logic [N-1:0]      tx_re = '0;
  logic [8*N-1:0]    tx_data;
  logic [N-1:0]      tx_busy;
  logic [16*N-1:0]   drop_cnt;

  e1_buf_arb_if #(.AW(AW)) mem_if ();

  e1_buf_arb #(.N(N), .MFW(MFW), .MFB(MFB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_ts    (rx_ts),
    .rx_frame (rx_frame),
    .rx_mf    (rx_mf),
    .rx_we    (rx_we),
    .tx_ts    (tx_ts),
    .tx_frame (tx_frame),
    .tx_mf    (tx_mf),
    .tx_re    (tx_re),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .mem      (mem_if),
    .drop_cnt (drop_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t;
  bit          mute = 1'b0;
  logic [7:0]  ram [1 << AW];
  logic [N-1:0] prev_busy = '0;
  mem_exp_t    mem_q [$];
  tx_exp_t     tx_q [$];
  mem_exp_t    me;
  tx_exp_t     te;

  // Free-running clock and cycle counter used to time-stamp expectations.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: serves reads one cycle after mem_re. Writes are checked
  // through the scoreboard, so the table is only ever filled by stimulus.
  always @(posedge clk) begin
    if (mem_if.mem_re) mem_if.mem_rdata <= ram[mem_if.mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int u, input logic [4:0] ts,
                                            input logic [3:0] fr,
                                            input logic [6:0] mf);
    logic [31:0] uu;
    uu = u;
    return {uu[0], mf[1:0], fr, ts};
  endfunction

  // Raise requester k's strobe with its coordinates for the next edge.
  task automatic applyStimulus(input int k, input logic [7:0] data,
                               input logic [4:0] ts, input logic [3:0] fr,
                               input logic [6:0] mf);
    int u;
    u = k / 2;
    if (k % 2 == 0) begin
      rx_we[u]           = 1'b1;
      rx_data[8*u +: 8]  = data;
      rx_ts[5*u +: 5]    = ts;
      rx_frame[4*u +: 4] = fr;
      rx_mf[7*u +: 7]    = mf;
    end else begin
      tx_re[u]           = 1'b1;
      tx_ts[5*u +: 5]    = ts;
      tx_frame[4*u +: 4] = fr;
      tx_mf[7*u +: 7]    = mf;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rx_we = '0;
      tx_re = '0;
    end
  endtask

  task automatic expect_mem(input logic we, input logic [AW-1:0] a,
                            input logic [7:0] d, input int c);
    mem_exp_t e;
    e.we = we; e.addr = a; e.wdata = d; e.cyc = c;
    mem_q.push_back(e);
  endtask

  // Queue a TX read: preload the RAM, strobe, and expect the read on the
  // bus one cycle after grant and in tx_data three cycles after grant.
  task automatic expect_read(input int u, input logic [4:0] ts,
                             input logic [3:0] fr, input logic [6:0] mf,
                             input logic [7:0] d, input int gcyc);
    tx_exp_t x;
    ram[addr_of(u, ts, fr, mf)] = d;
    applyStimulus(2*u + 1, 8'h00, ts, fr, mf);
    expect_mem(1'b0, addr_of(u, ts, fr, mf), 8'h00, gcyc + 1);
    x.unit = u; x.data = d; x.cyc = gcyc + 3;
    tx_q.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Monitor: RAM accesses and TX completions are popped from the
  // scoreboard and compared, including the cycle they appear on.
  always @(negedge clk) begin
    prev_busy <= tx_busy;
    if (!rst_n) begin
      checkOutput("no_strobe_in_reset", 32'({mem_if.mem_we, mem_if.mem_re}), 32'd0);
    end else begin
      if (mem_if.mem_we || mem_if.mem_re) begin
        checkOutput("we_re_exclusive", 32'(mem_if.mem_we & mem_if.mem_re), 32'd0);
        if (!mute) begin
          checkOutput("access_expected", 32'(mem_q.size() > 0), 32'd1);
          if (mem_q.size() > 0) begin
            me = mem_q.pop_front();
            checkOutput("acc_kind", 32'(mem_if.mem_we), 32'(me.we));
            checkOutput("acc_addr", 32'(mem_if.mem_addr), 32'(me.addr));
            checkOutput("acc_cycle", 32'(cyc), 32'(me.cyc));
            if (me.we) checkOutput("acc_wdata", 32'(mem_if.mem_wdata), 32'(me.wdata));
          end
        end
      end
      for (int u = 0; u < N; u++) begin
        if (!mute && prev_busy[u] && !tx_busy[u]) begin
          checkOutput("tx_expected", 32'(tx_q.size() > 0), 32'd1);
          if (tx_q.size() > 0) begin
            te = tx_q.pop_front();
            checkOutput("tx_unit", 32'(u), 32'(te.unit));
            checkOutput("tx_data", 32'(tx_data[8*u +: 8]), 32'(te.data));
            checkOutput("tx_cycle", 32'(cyc), 32'(te.cyc));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;

    // Reset state.
    step(3);
    checkOutput("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    checkOutput("rst_mem_re", 32'(mem_if.mem_re), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_if.mem_wdata), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_drop_cnt", drop_cnt, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Single RX write: unit 0, 0xA5, ts 3, frame 2, mf 5.
    t = cyc;
    applyStimulus(0, 8'hA5, 5'd3, 4'd2, 7'd5);
    expect_mem(1'b1, addr_of(0, 5'd3, 4'd2, 7'd5), 8'hA5, t + 2);
    step(1);
    checkOutput("rx_idle_t1", 32'(mem_if.mem_we), 32'd0);
    step(1);
    checkOutput("rx_we_t2", 32'(mem_if.mem_we), 32'd1);
    checkOutput("rx_addr_t2", 32'(mem_if.mem_addr), 32'h243);
    step(1);
    checkOutput("rx_single", 32'(mem_if.mem_we), 32'd0);
    step(2);

    // Single TX read on unit 1; RAM returns 0x3C.
    t = cyc;
    expect_read(1, 5'd7, 4'd4, 7'd9, 8'h3C, t + 1);
    step(1);
    checkOutput("busy_t1", 32'(tx_busy[1]), 32'd1);
    step(1);
    checkOutput("busy_t2", 32'(tx_busy[1]), 32'd1);
    step(1);
    checkOutput("busy_t3", 32'(tx_busy[1]), 32'd1);
    checkOutput("txdata_t3", 32'(tx_data[15:8]), 32'd0);
    step(1);
    checkOutput("busy_t4", 32'(tx_busy[1]), 32'd0);
    checkOutput("txdata_t4", 32'(tx_data[15:8]), 32'h3C);
    step(2);

    // All four requesters at once after reset: grants 0,1,2,3, then the
    // pointer is back at 0 so requester 0 beats requester 1.
    do_reset();
    checkOutput("rst_clears_tx_data", 32'(tx_data), 32'd0);
    t = cyc;
    applyStimulus(0, 8'h10, 5'd1, 4'd1, 7'd0);
    expect_mem(1'b1, addr_of(0, 5'd1, 4'd1, 7'd0), 8'h10, t + 2);
    expect_read(0, 5'd2, 4'd3, 7'd1, 8'h81, t + 2);
    applyStimulus(2, 8'h20, 5'd31, 4'd15, 7'd127);
    expect_mem(1'b1, 12'hFFF, 8'h20, t + 4);
    expect_read(1, 5'd0, 4'd0, 7'd2, 8'h92, t + 4);
    step(9);
    t = cyc;
    expect_read(0, 5'd4, 4'd4, 7'd4, 8'h55, t + 2);
    applyStimulus(0, 8'h99, 5'd5, 4'd6, 7'd3);
    mem_q.push_front('{we: 1'b1, addr: addr_of(0, 5'd5, 4'd6, 7'd3), wdata: 8'h99, cyc: t + 2});
    step(7);

    // Second strobe on requester 2 while it waits behind 0 and 1 is
    // dropped; the slot keeps the first request.
    do_reset();
    t = cyc;
    applyStimulus(0, 8'h30, 5'd5, 4'd5, 7'd5);
    expect_mem(1'b1, addr_of(0, 5'd5, 4'd5, 7'd5), 8'h30, t + 2);
    expect_read(0, 5'd6, 4'd6, 7'd6, 8'h66, t + 2);
    applyStimulus(2, 8'h40, 5'd7, 4'd7, 7'd7);
    expect_mem(1'b1, addr_of(1, 5'd7, 4'd7, 7'd7), 8'h40, t + 4);
    step(1);
    applyStimulus(2, 8'h41, 5'd8, 4'd8, 7'd8);
    step(7);
    checkOutput("drop_one", drop_cnt, DROP_ONE);

    // Overload: every requester strobes every cycle, so three of four are
    // dropped each cycle and all counters must pin at 0xFF.
    mute = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2*N; k++) applyStimulus(k, 8'hEE, 5'd9, 4'd9, 7'd9);
      step(1);
    end
    step(8);
    mute = 1'b0;
    checkOutput("drop_saturate", drop_cnt, DROP_SAT);

    // Reset while a TX read is in flight.
    t = cyc;
    ram[addr_of(1, 5'd9, 4'd9, 7'd9)] = 8'h77;
    applyStimulus(3, 8'h00, 5'd9, 4'd9, 7'd9);
    step(2);
    checkOutput("inflight_re", 32'(mem_if.mem_re), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_re", 32'(mem_if.mem_re), 32'd0);
    checkOutput("mid_rst_addr", 32'(mem_if.mem_addr), 32'd0);
    checkOutput("mid_rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("mid_rst_busy", 32'(tx_busy), 32'd0);
    checkOutput("mid_rst_drop", drop_cnt, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(4);
    checkOutput("post_rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("post_rst_busy", 32'(tx_busy), 32'd0);
    t = cyc;
    applyStimulus(2, 8'h5A, 5'd10, 4'd10, 7'd10);
    expect_mem(1'b1, addr_of(1, 5'd10, 4'd10, 7'd10), 8'h5A, t + 2);
    step(4);

    // Re-strobe in the cycle requester 0 is granted: both writes happen.
    t = cyc;
    applyStimulus(0, 8'h11, 5'd11, 4'd11, 7'd11);
    expect_mem(1'b1, addr_of(0, 5'd11, 4'd11, 7'd11), 8'h11, t + 2);
    step(1);
    applyStimulus(0, 8'h22, 5'd12, 4'd12, 7'd12);
    expect_mem(1'b1, addr_of(0, 5'd12, 4'd12, 7'd12), 8'h22, t + 3);
    step(5);
    checkOutput("coincident_no_drop", drop_cnt, 32'd0);

    step(4);
    checkOutput("mem_q_empty", 32'(mem_q.size()), 32'd0);
    checkOutput("tx_q_empty", 32'(tx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
